// File: rtl/wb_dsp_top.sv
// wb_dsp_top: chip-top Wishbone DSP subsystem.
//
// A command port launches single-beat transactions on an internal Wishbone
// master. The master reaches a 256x32 SRAM and a small DSP register block
// (DTB, ID, OPA, OPB, PROD, SUM). A 16-entry file-slot bank stores and recalls
// data_rd. The DTB register drives the debug test bus on dtb_pad.
//
// Ports:
//   clk_pad_i   system clock, rising edge
//   rst_pad_i   synchronous active-low reset
//   start       command strobe (sampled in IDLE only)
//   address     byte address; [1:0] ignored
//   selection   byte enables, bit n <-> data[8n+7:8n]
//   write       1 = write, 0 = read
//   data_wr     write data
//   file_num    file slot index ([7:4] must be 0 or the op is dropped)
//   file_read   load slot into data_rd
//   file_write  store data_rd into slot
//   data_rd     last read result
//   active      transaction in progress (BUS and ACK)
//   dtb_pad     debug test bus
//
// Configuration macro: DSP_MAC_EN -- when defined, the PROD multiplier is
// built and ID bit 0 is set; otherwise PROD reads 0 and ID bit 0 is clear.
module wb_dsp_top (
    input  logic        clk_pad_i,
    input  logic        rst_pad_i,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [3:0]  selection,
    input  logic        write,
    input  logic [31:0] data_wr,
    input  logic [7:0]  file_num,
    input  logic        file_read,
    input  logic        file_write,
    output logic [31:0] data_rd,
    output logic        active,
    output logic [31:0] dtb_pad
);

    typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

    state_t      state, state_next;

    // Latched command (word address only; byte offset is irrelevant)
    logic [29:0] adr_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [31:0] dat_q;

    logic [31:0] mem [0:255];
    logic [31:0] mem_q;
    logic [31:0] slot [0:15];
    logic [31:0] dtb, opa, opb;

    logic        sram_hit, reg_hit;
    logic [31:0] prod, sum, id_val;
    logic [31:0] reg_rdata, bus_rdata;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] d,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

`ifdef DSP_MAC_EN
    assign prod   = opa * opb;
    assign id_val = 32'hD5B0_0001;
`else
    assign prod   = 32'h0;
    assign id_val = 32'hD5B0_0000;
`endif
    assign sum = opa + opb;

    // SRAM occupies 0x0000_0000-0x0000_03FF; registers 0x8000_0000-0x8000_001F
    assign sram_hit = (adr_q[29:8] == '0);
    assign reg_hit  = (adr_q[29:3] == 27'h400_0000);

    always_comb begin
        reg_rdata = 32'h0;
        if (reg_hit) begin
            case (adr_q[2:0])
                3'd0:    reg_rdata = dtb;
                3'd1:    reg_rdata = id_val;
                3'd2:    reg_rdata = opa;
                3'd3:    reg_rdata = opb;
                3'd4:    reg_rdata = prod;
                3'd5:    reg_rdata = sum;
                default: reg_rdata = 32'h0;
            endcase
        end
    end

    assign bus_rdata = sram_hit ? mem_q : reg_rdata;

    // Master FSM
    always_ff @(posedge clk_pad_i) begin
        if (!rst_pad_i) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUS;
            BUS:     state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign active  = (state != IDLE);
    assign dtb_pad = dtb;

    // Command capture in IDLE
    always_ff @(posedge clk_pad_i) begin
        if (state == IDLE && start) begin
            adr_q <= address[31:2];
            sel_q <= selection;
            we_q  <= write;
            dat_q <= data_wr;
        end
    end

    // SRAM: the slave registers the read word during BUS; writes commit at
    // the ACK edge unless reset is asserted on that edge.
    always_ff @(posedge clk_pad_i) begin
        if (state == BUS)
            mem_q <= mem[adr_q[7:0]];
        if (rst_pad_i && state == ACK && we_q && sram_hit)
            mem[adr_q[7:0]] <= byte_merge(mem[adr_q[7:0]], dat_q, sel_q);
    end

    // Register block, read-data capture and file slots
    always_ff @(posedge clk_pad_i) begin
        if (!rst_pad_i) begin
            dtb     <= '0;
            opa     <= '0;
            opb     <= '0;
            data_rd <= '0;
            for (int i = 0; i < 16; i++) slot[i] <= '0;
        end else if (state == ACK) begin
            if (we_q) begin
                if (reg_hit) begin
                    case (adr_q[2:0])
                        3'd0:    dtb <= byte_merge(dtb, dat_q, sel_q);
                        3'd2:    opa <= byte_merge(opa, dat_q, sel_q);
                        3'd3:    opb <= byte_merge(opb, dat_q, sel_q);
                        default: ;
                    endcase
                end
            end else begin
                data_rd <= lane_mask(bus_rdata, sel_q);
            end
        end else if (state == IDLE && !start && file_num[7:4] == 4'h0) begin
            // file_write outranks file_read
            if (file_write)
                slot[file_num[3:0]] <= data_rd;
            else if (file_read)
                data_rd <= slot[file_num[3:0]];
        end
    end

endmodule

// File: tb/tb_wb_dsp_top.sv
// tb_wb_dsp_top: directed self-checking bench for wb_dsp_top.
module tb_wb_dsp_top;

    logic        clk_pad_i = 1'b0;
    logic        rst_pad_i = 1'b0;
    logic        start = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  selection = '0;
    logic        write = 1'b0;
    logic [31:0] data_wr = '0;
    logic [7:0]  file_num = '0;
    logic        file_read = 1'b0;
    logic        file_write = 1'b0;
    logic [31:0] data_rd;
    logic        active;
    logic [31:0] dtb_pad;

    int checks = 0;
    int failures = 0;

`ifdef DSP_MAC_EN
    localparam logic [31:0] ID_EXP   = 32'hD5B0_0001;
    localparam logic [31:0] PROD_EXP = 32'h0005_000F;
`else
    localparam logic [31:0] ID_EXP   = 32'hD5B0_0000;
    localparam logic [31:0] PROD_EXP = 32'h0000_0000;
`endif

    wb_dsp_top dut (
        .clk_pad_i (clk_pad_i),
        .rst_pad_i (rst_pad_i),
        .start     (start),
        .address   (address),
        .selection (selection),
        .write     (write),
        .data_wr   (data_wr),
        .file_num  (file_num),
        .file_read (file_read),
        .file_write(file_write),
        .data_rd   (data_rd),
        .active    (active),
        .dtb_pad   (dtb_pad)
    );

    always #5 clk_pad_i = ~clk_pad_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_pad_i);
        rst_pad_i = 1'b0;
        repeat (2) @(negedge clk_pad_i);
        rst_pad_i = 1'b1;
    endtask

    // Issues one command and returns at the negedge of cycle N+3.
    task automatic bus_op(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic w, input logic [31:0] d);
        int n;
        @(negedge clk_pad_i);
        start = 1'b1; address = a; selection = s; write = w; data_wr = d;
        @(negedge clk_pad_i);
        start = 1'b0;
        n = 0;
        while (active && n < 10) begin
            n++;
            @(negedge clk_pad_i);
        end
        chk(tag, n, 32'd2);
    endtask

    task automatic file_op(input logic [7:0] num, input logic rd, input logic wr);
        @(negedge clk_pad_i);
        file_num = num; file_read = rd; file_write = wr;
        @(negedge clk_pad_i);
        file_read = 1'b0; file_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_active", {31'b0, active}, 32'h0);
        chk("rst_data_rd", data_rd, 32'h0);
        chk("rst_dtb", dtb_pad, 32'h0);
        bus_op("act_id", 32'h8000_0004, 4'hF, 1'b0, 32'h0);
        chk("id", data_rd, ID_EXP);

        // SRAM write/read
        bus_op("act_w10", 32'h0000_0010, 4'hF, 1'b1, 32'h1234_5678);
        chk("write_keeps_rd", data_rd, ID_EXP);
        bus_op("act_r10", 32'h0000_0010, 4'hF, 1'b0, 32'h0);
        chk("sram_rd", data_rd, 32'h1234_5678);

        // Byte enables
        bus_op("act_w20a", 32'h0000_0020, 4'hF, 1'b1, 32'h0);
        bus_op("act_w20b", 32'h0000_0022, 4'h5, 1'b1, 32'hAABB_CCDD);
        bus_op("act_r20", 32'h0000_0020, 4'hF, 1'b0, 32'h0);
        chk("be_write", data_rd, 32'h00BB_00DD);
        bus_op("act_r20s3", 32'h0000_0020, 4'h3, 1'b0, 32'h0);
        chk("be_read", data_rd, 32'h0000_00DD);
        bus_op("act_w20z", 32'h0000_0020, 4'h0, 1'b1, 32'hFFFF_FFFF);
        bus_op("act_r20z", 32'h0000_0020, 4'hF, 1'b0, 32'h0);
        chk("sel0_write", data_rd, 32'h00BB_00DD);

        // DSP registers
        bus_op("act_opa", 32'h8000_0008, 4'hF, 1'b1, 32'h0001_0003);
        bus_op("act_opb", 32'h8000_000C, 4'hF, 1'b1, 32'h0000_0005);
        bus_op("act_prod", 32'h8000_0010, 4'hF, 1'b0, 32'h0);
        chk("prod", data_rd, PROD_EXP);
        bus_op("act_sumw", 32'h8000_0014, 4'hF, 1'b1, 32'hFFFF_FFFF);
        bus_op("act_sum", 32'h8000_0014, 4'hF, 1'b0, 32'h0);
        chk("sum", data_rd, 32'h0001_0008);
        bus_op("act_opar", 32'h8000_0008, 4'hF, 1'b0, 32'h0);
        chk("opa_rd", data_rd, 32'h0001_0003);

        // DTB write timing: visible from N+3
        @(negedge clk_pad_i);
        start = 1'b1; address = 32'h8000_0000; selection = 4'hF; write = 1'b1; data_wr = 32'hCAFE_F00D;
        @(negedge clk_pad_i);
        start = 1'b0;
        chk("dtb_n1", dtb_pad, 32'h0);
        @(negedge clk_pad_i);
        chk("dtb_n2", dtb_pad, 32'h0);
        @(negedge clk_pad_i);
        chk("dtb_n3", dtb_pad, 32'hCAFE_F00D);
        chk("dtb_n3_idle", {31'b0, active}, 32'h0);

        // File slots
        bus_op("act_w40", 32'h0000_0040, 4'hF, 1'b1, 32'h0000_0055);
        bus_op("act_r40", 32'h0000_0040, 4'hF, 1'b0, 32'h0);
        file_op(8'h03, 1'b0, 1'b1);
        chk("fw_keeps_rd", data_rd, 32'h0000_0055);
        chk("fw_no_active", {31'b0, active}, 32'h0);
        bus_op("act_r10b", 32'h0000_0010, 4'hF, 1'b0, 32'h0);
        file_op(8'h03, 1'b1, 1'b0);
        chk("file_read", data_rd, 32'h0000_0055);
        bus_op("act_r10c", 32'h0000_0010, 4'hF, 1'b0, 32'h0);
        file_op(8'h13, 1'b1, 1'b0);
        chk("file_badnum", data_rd, 32'h1234_5678);
        file_op(8'h05, 1'b1, 1'b1);
        chk("fw_wins_rd", data_rd, 32'h1234_5678);
        bus_op("act_r40b", 32'h0000_0040, 4'hF, 1'b0, 32'h0);
        file_op(8'h05, 1'b1, 1'b0);
        chk("fw_wins_slot", data_rd, 32'h1234_5678);

        // start while active is ignored
        @(negedge clk_pad_i);
        start = 1'b1; address = 32'h0000_0050; selection = 4'hF; write = 1'b1; data_wr = 32'h0000_0011;
        @(negedge clk_pad_i);
        data_wr = 32'h0000_0022;
        chk("busy_bus", {31'b0, active}, 32'h1);
        @(negedge clk_pad_i);
        chk("busy_ack", {31'b0, active}, 32'h1);
        @(negedge clk_pad_i);
        start = 1'b0;
        chk("busy_done", {31'b0, active}, 32'h0);
        @(negedge clk_pad_i);
        chk("busy_no_second", {31'b0, active}, 32'h0);
        bus_op("act_r50", 32'h0000_0050, 4'hF, 1'b0, 32'h0);
        chk("busy_data", data_rd, 32'h0000_0011);

        // Reset during BUS of a DTB write
        do_reset();
        chk("rst2_dtb", dtb_pad, 32'h0);
        @(negedge clk_pad_i);
        start = 1'b1; address = 32'h8000_0000; selection = 4'hF; write = 1'b1; data_wr = 32'h1234_5678;
        @(negedge clk_pad_i);
        start = 1'b0;
        rst_pad_i = 1'b0;
        @(negedge clk_pad_i);
        rst_pad_i = 1'b1;
        repeat (3) @(negedge clk_pad_i);
        chk("rst_bus_dtb", dtb_pad, 32'h0);
        chk("rst_bus_active", {31'b0, active}, 32'h0);

        // Reset during ACK of an SRAM write
        bus_op("act_w60", 32'h0000_0060, 4'hF, 1'b1, 32'h0000_0077);
        @(negedge clk_pad_i);
        start = 1'b1; address = 32'h0000_0060; selection = 4'hF; write = 1'b1; data_wr = 32'h0000_0099;
        @(negedge clk_pad_i);
        start = 1'b0;
        @(negedge clk_pad_i);
        rst_pad_i = 1'b0;
        @(negedge clk_pad_i);
        rst_pad_i = 1'b1;
        bus_op("act_r60", 32'h0000_0060, 4'hF, 1'b0, 32'h0);
        chk("rst_ack_sram", data_rd, 32'h0000_0077);

        // Slots cleared by reset
        file_op(8'h03, 1'b1, 1'b0);
        chk("rst_slot", data_rd, 32'h0);

        // Unmapped addresses
        bus_op("act_r10d", 32'h0000_0010, 4'hF, 1'b0, 32'h0);
        bus_op("act_unm", 32'h9000_0000, 4'hF, 1'b0, 32'h0);
        chk("unmapped_rd", data_rd, 32'h0);
        bus_op("act_unmw", 32'h9000_0010, 4'hF, 1'b1, 32'hDEAD_BEEF);
        bus_op("act_r10e", 32'h0000_0010, 4'hF, 1'b0, 32'h0);
        chk("unmapped_wr", data_rd, 32'h1234_5678);
        bus_op("act_r18", 32'h8000_0018, 4'hF, 1'b0, 32'h0);
        chk("reg_hole", data_rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_dsp_top.md
# wb_dsp_top

Top-level Wishbone DSP subsystem. A command port (start/address/selection/write/data) drives a single-beat internal Wishbone master. The master reaches a 256-word SRAM and a small DSP register block. A 16-entry "file slot" bank lets a test harness stash and recall read data. The block sits at chip top: clocks and reset come from pads, and a 32-bit debug test bus (dtb_pad) is driven from a software-writable register.

## Interface
- No parameters; sizes fixed: SRAM 256×32, 16 file slots.
- clk_pad_i  in  1  system clock, all logic on rising edge
- rst_pad_i  in  1  reset; **one clock; reset is synchronous and active-low**
- start  in  1  single-cycle command strobe
- address  in  32  byte address of command
- selection  in  4  byte enables, bit n ↔ data[8n+7:8n]
- write  in  1  1 = write, 0 = read
- data_wr  in  32  write data
- file_num  in  8  file slot index; [3:0] used, [7:4] must be 0
- file_read  in  1  strobe: load slot into data_rd
- file_write  in  1  strobe: store data_rd into slot
- data_rd  out  32  last read result
- active  out  1  bus transaction in progress
- dtb_pad  out  32  debug test bus = DTB register

## Operation
- Master FSM: IDLE → BUS → ACK → IDLE.
  - IDLE: start=1 latches address, selection, write and data_wr, then goes to BUS.
  - BUS: cyc/stb asserted; the slave registers the request.
  - ACK: slave ack. Writes commit at this edge; read data is captured into data_rd at this edge.
- Address map (addr[1:0] ignored):
  - 0x0000_0000–0x0000_03FF: SRAM, word index addr[9:2].
  - 0x8000_0000 DTB (R/W): drives dtb_pad.
  - 0x8000_0004 ID (RO): 0xD5B0_0001.
  - 0x8000_0008 OPA (R/W).
  - 0x8000_000C OPB (R/W).
  - 0x8000_0010 PROD (RO): (OPA×OPB)[31:0], unsigned.
  - 0x8000_0014 SUM (RO): OPA+OPB mod 2^32.
  - Any other address: writes dropped, reads return 0. The transaction still completes normally.
- Writes honour selection per byte. selection=0 writes nothing.
- Reads: data_rd byte lanes with selection bit 0 are forced to 0.
- Writes leave data_rd unchanged.
- Writes to RO registers are ignored.
- File ops (IDLE only, start=0):
  - file_write: slot[file_num[3:0]] ← data_rd.
  - file_read: data_rd ← slot[file_num[3:0]].
  - file_num[7:4]≠0: op ignored.
  - file_read and file_write in the same cycle: file_write wins.
- Priority in IDLE: start > file_write > file_read.
- start, file_read and file_write are ignored while active=1.

## Timing
- Reset (rst_pad_i=0 at a rising edge): FSM to IDLE; active=0, data_rd=0, dtb_pad=0; DTB, OPA, OPB and file slots cleared. SRAM contents are not reset.
- Reset takes priority over every other event. Reset in BUS or ACK aborts the transaction with no write committed.
- start sampled high at edge N: active=1 during cycles N+1 (BUS) and N+2 (ACK); active=0 from N+3.
- Read data is valid on data_rd from cycle N+3. A write's effect (including dtb_pad) is visible from N+3.
- Back-to-back: a start asserted in the first cycle active=0 (N+3) is accepted. Peak throughput is one transaction per 3 cycles.
- File op sampled at edge N: the slot or data_rd is updated and visible from N+1. active never asserts for file ops.
- PROD and SUM are combinational on OPA/OPB and reflect the values at the read's ACK edge.

## Configuration
- DSP_MAC_EN defined: the PROD multiplier is implemented as described.
- DSP_MAC_EN undefined: no multiplier is synthesized. PROD reads return 0. ID reads 0xD5B0_0000 (bit 0 flags MAC presence).

## Test plan
- Reset: hold rst_pad_i=0 for 2 cycles, then release → active=0, data_rd=0, dtb_pad=0; read ID → 0xD5B0_0001 (MAC on).
- SRAM write/read: write 0x1234_5678 to 0x0000_0010 with sel=F, then read back → data_rd=0x1234_5678. active is high exactly 2 cycles per transaction.
- Byte enables: write 0xAABB_CCDD with sel=0x5 over a word holding 0, then read with sel=F → 0x00BB_00DD; read with sel=0x3 → 0x0000_00DD.
- DSP: write OPA=0x0001_0003 and OPB=0x0000_0005 → PROD reads 0x0005_000F; SUM reads 0x0001_0008. Write DTB=0xCAFE_F00D → dtb_pad=0xCAFE_F00D from cycle N+3.
- File slots: read SRAM value 0x55 → file_write with file_num=3; read another word → file_read with file_num=3 → data_rd=0x55. file_num=0x13 → no change.
- Boundaries:
  - start while active → ignored; only one transaction occurs.
  - Reset asserted during BUS of a write to DTB → dtb_pad stays 0.
  - Read of 0x9000_0000 → data_rd=0 and active completes normally.
